sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
- Synchronous command stage directly upstream of the team's SR latch (`sr_latch`).
- Converts single-cycle set/clear requests from clocked logic into glitch-free, timed drive pulses on the latch's `s`/`r` pins.
- Guarantees the forbidden combination (`s=0`, `r=0`) is never driven.
- Reads back latch `q` after a settle window and reports completion or error.

Parameters:
- PULSE_CYC, 4, cycles the drive pin is held low (legal range 1..255).
- SETTLE_CYC, 2, hold cycles after the pulse before `q` is checked (legal range 0..255; 0 skips SETTLE).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- set_req  input  1  request latch `q`=1; sampled only in IDLE.
- clr_req  input  1  request latch `q`=0; sampled only in IDLE.
- q_fb  input  1  latch `q` feedback; treated as already synchronous to `clk`.
- s_out  output  1  registered, drives latch `s`.
- r_out  output  1  registered, drives latch `r`.
- busy  output  1  high while a command is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  `q_fb` mismatched target at check; held until the next accepted command or reset.
- conflict  output  1  one-cycle pulse when `set_req` and `clr_req` are both high in IDLE.

Behaviour:
- Latch pin semantics:
  - `s=1`, `r=1`: hold.
  - `s=0`, `r=1`: forces `q=0`.
  - `s=1`, `r=0`: forces `q=1`.
  - `s=0`, `r=0`: forbidden.
- Invariant: `s_out` and `r_out` are never both 0 in any cycle, including reset and abort.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: `s_out`=1, `r_out`=1, `busy`=0, `done`=0, `err`=0, `conflict`=0, state=IDLE, counter=0.
- Reset has priority over everything. Reset during any state returns `s_out`/`r_out` to 1/1 at that edge and discards the command.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - `set_req`=1 and `clr_req`=1: no accept; `conflict`=1 for the next cycle; stay IDLE.
  - Exactly one request high and target==`q_fb` (no-op): no drive; `done`=1 next cycle; `err` cleared; stay IDLE; `busy` stays 0.
  - Exactly one request high and target!=`q_fb`: latch the target, clear `err`, go to DRIVE, load counter = PULSE_CYC-1.
    - Set target (1): `r_out`=0.
    - Clear target (0): `s_out`=0.
    - The drive value is visible from the accept edge.
- DRIVE:
  - Hold the drive pin low for exactly PULSE_CYC cycles, decrementing the counter.
  - At counter 0: release both pins to 1.
  - Then go to SETTLE (counter = SETTLE_CYC-1), or to CHECK if SETTLE_CYC=0.
- SETTLE: both pins 1 for SETTLE_CYC cycles, then CHECK.
- CHECK (1 cycle):
  - Compare `q_fb` to target.
  - At the exit edge: `done`=1 for one cycle; `err`=1 if mismatch; go to IDLE.
- Requests arriving while `busy`=1 are ignored, not queued. Requests are level-sampled, so a request still high on return to IDLE is accepted again.
- `busy` = (state != IDLE); it is registered with the state.
- Total latency from the accept edge to the `done` edge = PULSE_CYC + SETTLE_CYC + 1 cycles (7 with defaults).
- Counter width is 8 bits.

Test Plan:
- Set with defaults: reset 2 cycles; `q_fb` modelled by an instantiated `sr_latch` starting at 0; `set_req` pulsed 1 cycle → `r_out`=0 for exactly 4 cycles, `s_out`=1 throughout; 2 hold cycles; `done`=1 on the 7th edge after accept; `err`=0; `q_fb`=1; `busy` high exactly 7 cycles.
- Clear with latch at 1: `clr_req` pulsed → `s_out`=0 for 4 cycles, `r_out`=1; `done` after 7 cycles; `q_fb`=0; `err`=0.
- No-op and conflict:
  - `clr_req` with `q_fb`=0 → `done` next cycle, `s_out`/`r_out` stay 1/1, `busy` stays 0.
  - `set_req` and `clr_req` high together → `conflict`=1 for one cycle, no drive, `busy`=0.
- Stuck latch: `q_fb` forced 0 and `set_req` → full pulse sequence, then `done`=1 with `err`=1; the next accepted `clr_req` clears `err` at the accept edge.
- Busy and abort:
  - `clr_req` in the 2nd DRIVE cycle of a set → ignored, only one `done`.
  - `rst` in the 3rd DRIVE cycle → `s_out`=`r_out`=1 at that edge, `busy`=0, no `done`.
- Invariant sweep: 2000 cycles of random `set_req`/`clr_req`/`rst` with PULSE_CYC=1, SETTLE_CYC=0 and with the defaults → assertion that (`s_out`|`r_out`)==1 every cycle, and `done` never overlaps `conflict`.

Source files
------------

// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Synchronous command stage in front of an active-low SR latch. Single-cycle
// set/clear requests become timed drive pulses on the latch s/r pins. After
// the pulse and an optional settle window, the latch q is read back and the
// result is reported.
//
// The pins are active-low: s=1/r=1 holds, s=0 clears q, r=0 sets q. s=0/r=0
// is forbidden. At most one pin is ever pulled low, and reset releases both.
//
// Parameters
//   PULSE_CYC   cycles the selected pin is held low (1..255)
//   SETTLE_CYC  cycles both pins are held high before q is checked
//               (0..255; 0 goes straight from the pulse to the check)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   set_req   request q=1 (sampled only while idle)
//   clr_req   request q=0 (sampled only while idle)
//   q_fb      latch q feedback, already synchronous to clk
//   s_out     registered drive for latch s (low = clear)
//   r_out     registered drive for latch r (low = set)
//   busy      high while a command is in progress
//   done      one-cycle pulse when a command (or a no-op) completes
//   err       q_fb differed from the target at check; held until the next
//             accepted command or reset
//   conflict  one-cycle pulse when both requests are high while idle
// -----------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s_out,
    output logic r_out,
    output logic busy,
    output logic done,
    output logic err,
    output logic conflict
);

    // Counter reload values. The counter counts down to zero, so a window of
    // N cycles is loaded with N-1.
    localparam logic [7:0] PULSE_LD  = 8'(PULSE_CYC - 1);
    localparam logic [7:0] SETTLE_LD = (SETTLE_CYC == 0) ? 8'd0 : 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       tgt_reg, tgt_next;
    logic       s_reg, s_next;
    logic       r_reg, r_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic       conflict_reg, conflict_next;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            tgt_reg      <= 1'b0;
            s_reg        <= 1'b1;
            r_reg        <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            tgt_reg      <= tgt_next;
            s_reg        <= s_next;
            r_reg        <= r_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            conflict_reg <= conflict_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        tgt_next      = tgt_reg;
        s_next        = s_reg;
        r_next        = r_reg;
        err_next      = err_reg;
        done_next     = 1'b0;
        conflict_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (set_req && clr_req) begin
                    conflict_next = 1'b1;
                end else if (set_req || clr_req) begin
                    // With exactly one request high, set_req is the target.
                    err_next = 1'b0;
                    if (set_req == q_fb) begin
                        // Latch is already where it should be: report done
                        // without touching the pins.
                        done_next = 1'b1;
                    end else begin
                        tgt_next   = set_req;
                        state_next = DRIVE;
                        cnt_next   = PULSE_LD;
                        // Pull exactly one pin low. A set drives r low and a
                        // clear drives s low, so both can never be low.
                        s_next     = set_req;
                        r_next     = ~set_req;
                    end
                end
            end

            DRIVE: begin
                if (cnt_reg == 8'd0) begin
                    s_next = 1'b1;
                    r_next = 1'b1;
                    if (SETTLE_CYC == 0) begin
                        state_next = CHECK;
                        cnt_next   = 8'd0;
                    end else begin
                        state_next = SETTLE;
                        cnt_next   = SETTLE_LD;
                    end
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end

            SETTLE: begin
                if (cnt_reg == 8'd0) begin
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end

            CHECK: begin
                done_next  = 1'b1;
                err_next   = (q_fb != tgt_reg);
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                s_next     = 1'b1;
                r_next     = 1'b1;
            end
        endcase

        // busy is registered alongside the state so it tracks the state exactly.
        busy_next = (state_next != IDLE);
    end

    assign s_out    = s_reg;
    assign r_out    = r_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign conflict = conflict_reg;

endmodule

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Two driver instances run side by side: one with default timing (4/2) and a
// fast one (1/0). Each feeds a small behavioural SR latch. The main latch can
// be forced to a stuck value. Every cycle, each instance is compared against
// a command-timeline reference model. That model tracks how many edges have
// passed since a command was accepted and derives the expected pin, busy,
// done and err values from that age.
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;

    logic [1:0] s_o, r_o, busy_o, done_o, err_o, conf_o;
    logic q0 = 1'b0;
    logic q1 = 1'b0;
    logic stuck = 1'b0;
    logic stuck_val = 1'b0;

    always #5 clk = ~clk;

    sr_latch_driver dut (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q0),
        .s_out(s_o[0]), .r_out(r_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .err(err_o[0]), .conflict(conf_o[0])
    );

    sr_latch_driver #(.PULSE_CYC(1), .SETTLE_CYC(0)) dut_fast (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q1),
        .s_out(s_o[1]), .r_out(r_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .err(err_o[1]), .conflict(conf_o[1])
    );

    // Behavioural active-low SR latches. q moves one edge after a drive.
    always @(posedge clk) begin
        if (stuck)                 q0 <= stuck_val;
        else if (s_o[0] && !r_o[0]) q0 <= 1'b1;
        else if (!s_o[0] && r_o[0]) q0 <= 1'b0;
    end
    always @(posedge clk) begin
        if (s_o[1] && !r_o[1])      q1 <= 1'b1;
        else if (!s_o[1] && r_o[1]) q1 <= 1'b0;
    end

    // ---------------- reference model ----------------
    int mp [2] = '{4, 1};   // pulse length per instance
    int ms [2] = '{2, 0};   // settle length per instance
    bit m_cmd [2];
    int m_age [2];
    bit m_tgt [2];
    bit m_err [2];
    bit e_s [2], e_r [2], e_busy [2], e_done [2], e_conf [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cnt_rlow, cnt_slow, cnt_busy, cnt_done, last_done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Predict the outputs after the coming edge from the inputs and q present now.
    task automatic model_step(input int k, input bit qv);
        bit low;
        e_done[k] = 1'b0;
        e_conf[k] = 1'b0;
        if (rst) begin
            m_cmd[k] = 1'b0;
            m_err[k] = 1'b0;
        end else if (m_cmd[k]) begin
            m_age[k]++;
            if (m_age[k] == mp[k] + ms[k] + 1) begin
                e_done[k] = 1'b1;
                m_err[k]  = (qv != m_tgt[k]);
                m_cmd[k]  = 1'b0;
            end
        end else if (set_req && clr_req) begin
            e_conf[k] = 1'b1;
        end else if (set_req || clr_req) begin
            m_err[k] = 1'b0;
            if (set_req == qv) begin
                e_done[k] = 1'b1;
            end else begin
                m_cmd[k] = 1'b1;
                m_age[k] = 0;
                m_tgt[k] = set_req;
            end
        end
        low       = m_cmd[k] && (m_age[k] < mp[k]);
        e_s[k]    = !(low && !m_tgt[k]);
        e_r[k]    = !(low && m_tgt[k]);
        e_busy[k] = m_cmd[k];
    endtask

    // One clock: predict, advance, compare both instances.
    task automatic cycle();
        model_step(0, q0);
        model_step(1, q1);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("s_out[%0d]", k),    32'(s_o[k]),    32'(e_s[k]));
            check($sformatf("r_out[%0d]", k),    32'(r_o[k]),    32'(e_r[k]));
            check($sformatf("busy[%0d]", k),     32'(busy_o[k]), 32'(e_busy[k]));
            check($sformatf("done[%0d]", k),     32'(done_o[k]), 32'(e_done[k]));
            check($sformatf("err[%0d]", k),      32'(err_o[k]),  32'(m_err[k]));
            check($sformatf("conflict[%0d]", k), 32'(conf_o[k]), 32'(e_conf[k]));
            check($sformatf("pins_not_both_low[%0d]", k), 32'(s_o[k] | r_o[k]), 32'd1);
            check($sformatf("done_and_conflict[%0d]", k), 32'(done_o[k] & conf_o[k]), 32'd0);
        end
        cnt_rlow += int'(!r_o[0]);
        cnt_slow += int'(!s_o[0]);
        cnt_busy += int'(busy_o[0]);
        if (done_o[0]) begin
            cnt_done++;
            last_done_cyc = cyc;
            $display("txn: cycle %0d done err=%b q_fb=%b", cyc, err_o[0], q0);
        end
    endtask

    task automatic clear_counters();
        cnt_rlow = 0; cnt_slow = 0; cnt_busy = 0; cnt_done = 0; last_done_cyc = -1;
    endtask

    int accept_cyc;

    initial begin
        clear_counters();

        // Reset for 2 cycles.
        rst = 1'b1;
        cycle();
        cycle();
        check("reset_s_out", 32'(s_o[0]), 32'd1);
        check("reset_r_out", 32'(r_o[0]), 32'd1);
        check("reset_busy",  32'(busy_o[0]), 32'd0);
        rst = 1'b0;
        cycle();

        // Set with the latch at 0.
        clear_counters();
        set_req = 1'b1;
        cycle();
        accept_cyc = cyc;
        set_req = 1'b0;
        repeat (9) cycle();
        check("set_r_low_cycles", 32'(cnt_rlow), 32'd4);
        check("set_s_low_cycles", 32'(cnt_slow), 32'd0);
        check("set_busy_cycles",  32'(cnt_busy), 32'd7);
        check("set_done_count",   32'(cnt_done), 32'd1);
        check("set_latency",      32'(last_done_cyc - accept_cyc), 32'd7);
        check("set_err",          32'(err_o[0]), 32'd0);
        check("set_q_fb",         32'(q0), 32'd1);

        // Clear with the latch at 1.
        clear_counters();
        clr_req = 1'b1;
        cycle();
        accept_cyc = cyc;
        clr_req = 1'b0;
        repeat (9) cycle();
        check("clr_s_low_cycles", 32'(cnt_slow), 32'd4);
        check("clr_r_low_cycles", 32'(cnt_rlow), 32'd0);
        check("clr_latency",      32'(last_done_cyc - accept_cyc), 32'd7);
        check("clr_q_fb",         32'(q0), 32'd0);
        check("clr_err",          32'(err_o[0]), 32'd0);

        // No-op clear while q is already 0.
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        check("noop_done", 32'(done_o[0]), 32'd1);
        check("noop_busy", 32'(busy_o[0]), 32'd0);
        check("noop_pins", 32'({s_o[0], r_o[0]}), 32'd3);
        cycle();

        // Conflict.
        set_req = 1'b1;
        clr_req = 1'b1;
        cycle();
        set_req = 1'b0;
        clr_req = 1'b0;
        check("conflict_pulse", 32'(conf_o[0]), 32'd1);
        check("conflict_busy",  32'(busy_o[0]), 32'd0);
        cycle();
        check("conflict_one_cycle", 32'(conf_o[0]), 32'd0);

        // Stuck-at-0 latch: a set finishes with err.
        stuck = 1'b1;
        stuck_val = 1'b0;
        cycle();
        clear_counters();
        set_req = 1'b1;
        cycle();
        set_req = 1'b0;
        repeat (9) cycle();
        check("stuck_done_count", 32'(cnt_done), 32'd1);
        check("stuck_err",        32'(err_o[0]), 32'd1);

        // Stuck at 1, so a clear is accepted. err drops at the accept edge.
        stuck_val = 1'b1;
        cycle();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        check("accept_clears_err", 32'(err_o[0]), 32'd0);
        check("accept_busy",       32'(busy_o[0]), 32'd1);
        repeat (9) cycle();
        check("stuck1_err", 32'(err_o[0]), 32'd1);
        stuck = 1'b0;
        cycle();

        // Bring the latch to 0, then issue a set with a clear during DRIVE.
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (9) cycle();
        clear_counters();
        set_req = 1'b1;
        cycle();
        set_req = 1'b0;
        cycle();
        clr_req = 1'b1;       // second DRIVE cycle
        cycle();
        clr_req = 1'b0;
        repeat (8) cycle();
        check("ignored_req_done_count", 32'(cnt_done), 32'd1);
        check("ignored_req_q_fb",       32'(q0), 32'd1);

        // Abort a clear with reset in its third DRIVE cycle.
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        cycle();
        cycle();
        clear_counters();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_pins", 32'({s_o[0], r_o[0]}), 32'd3);
        check("abort_busy", 32'(busy_o[0]), 32'd0);
        repeat (10) cycle();
        check("abort_no_done", 32'(cnt_done), 32'd0);

        // Random sweep on both instances.
        for (int i = 0; i < 2000; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            set_req = ($urandom_range(0, 3) == 0);
            clr_req = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst = 1'b0;
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
